bus_hs_arbiter: RTL

- Round-robin arbiter that shares one valid/ready bus slave between N valid/ready bus masters.
- Each requester presents `valid`/`data` and receives `ready`. The arbiter grants one requester at a time and connects it to the single downstream port. It holds the grant until that requester's transfer completes, then moves priority to the next requester.
- Sits between multiple master instances and one slave instance in the bus-handshake design.
- Also flags handshake-protocol violations by the granted master.

---
 rtl/bus_hs_pkg.sv | 14 +
 rtl/bus_hs_arbiter_rr_pick.sv | 34 +++
 rtl/bus_hs_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bus_hs_pkg.sv
// Shared definitions for the bus-handshake design: arbiter FSM states and the
// default payload width used by the master, slave and arbiter blocks.
package bus_hs_pkg;

  // Arbiter FSM: waiting for requests, or holding a grant until its beat completes.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Default payload width shared by all bus-handshake blocks.
  localparam int unsigned DefaultDataW = 3;

endpackage

// File: rtl/bus_hs_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found when
// searching upward from ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int unsigned pos;
    logic [IdxW-1:0] pos_w;
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    pos_w = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos   = (32'(ptr) + k) % N;
      pos_w = IdxW'(pos);
      if (!any && req[pos_w]) begin
        any        = 1'b1;
        gnt[pos_w] = 1'b1;
        idx        = pos_w;
      end
    end
  end

endmodule

// File: rtl/bus_hs_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave between N valid/ready
// masters. One grant at a time, held until its beat transfers; flags a granted
// master that drops valid or changes data before its beat is accepted.
module bus_hs_arbiter
  import bus_hs_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [N-1:0]        req_valid,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic [N-1:0]        grant,
  output logic                busy,
  output logic                err
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  arb_state_e        state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]   gidx_q, gidx_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              err_q, err_d;

  logic [N-1:0]      pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_any;
  logic [DATA_W-1:0] pick_data;

  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              xfer;
  logic              valid_drop;
  logic              data_change;
  logic [IdxW-1:0]   ptr_after;

  rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the granted requester's valid/data; grant is zero in IDLE, so both read as 0 there.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Payload of the requester the picker would grant this cycle.
  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_gnt[i]) begin
        pick_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Downstream mux and ready fan-back, combinational through the registered grant.
  always_comb begin
    busy      = (state_q == StBusy);
    grant     = grant_q;
    err       = err_q;
    out_valid = busy & g_valid;
    out_data  = busy ? g_data : '0;
    req_ready = grant_q & {N{out_ready}};
  end

  // Handshake events and the priority pointer used after the current grant ends.
  always_comb begin
    xfer        = out_valid & out_ready;
    valid_drop  = busy & ~g_valid;
    data_change = busy & g_valid & (g_data != hold_data_q);
    ptr_after   = (gidx_q == IdxW'(N - 1)) ? '0 : gidx_q + 1'b1;
  end

  // FSM next state: arbitrate in IDLE, hold grant in BUSY until transfer or abort.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    hold_data_d = hold_data_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d     = StBusy;
          grant_d     = pick_gnt;
          gidx_d      = pick_idx;
          hold_data_d = pick_data;
        end
      end
      StBusy: begin
        // A data change keeps the grant; the new payload becomes the reference.
        if (data_change) begin
          err_d       = 1'b1;
          hold_data_d = g_data;
        end
        if (valid_drop) begin
          err_d = 1'b1;
        end
        if (xfer || valid_drop) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = ptr_after;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      ptr_q       <= '0;
      hold_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      hold_data_q <= hold_data_d;
      err_q       <= err_d;
    end
  end

endmodule
